// File: rtl/sram_pattern_tester.sv
// Write/read-back pattern sequencer for the 2Kx16 SRAM; reports pass/fail, error count and first failing address.
// Define SRAM_TESTER_INVERT_PASS_EN to add a second pass that writes and checks the inverted pattern.
module sram_pattern_tester #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned LAST_ADDR = 2047,
    parameter int unsigned READ_LAT  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W+1:0]   err_count,
    output logic [ADDR_W-1:0]   first_err_adx,
    output logic [ADDR_W-1:0]   mem_adx,
    output logic                mem_wren,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned ERR_W = ADDR_W + 2;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LAST_ADDR);
    localparam logic [1:0] DRAIN_LAST = 2'(READ_LAT - 1);
`ifdef SRAM_TESTER_INVERT_PASS_EN
    localparam logic TWO_PASS = 1'b1;
`else
    localparam logic TWO_PASS = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   adx_q;
    logic                wren_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [ERR_W-1:0]    err_q;
    logic [ERR_W-1:0]    err_d;
    logic [ADDR_W-1:0]   first_q;
    logic                inv_q;
    logic [1:0]          drain_q;
    logic                mismatch_c;

    // Expected word, address and valid flag travel alongside the read request
    logic [READ_LAT-1:0] vld_q;
    logic [DATA_W-1:0]   exp_q  [READ_LAT];
    logic [ADDR_W-1:0]   eadx_q [READ_LAT];

    function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a, input logic inv);
        logic [7:0]        lo;
        logic [DATA_W-1:0] p;
        lo = 8'(a);
        p  = DATA_W'({lo, ~lo});
        return inv ? ~p : p;
    endfunction

    always_comb begin
        err_d      = err_q;
        mismatch_c = vld_q[READ_LAT-1] && (mem_rdata != exp_q[READ_LAT-1]);
        if (mismatch_c && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            adx_q   <= '0;
            wren_q  <= 1'b1;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            first_q <= '0;
            inv_q   <= 1'b0;
            drain_q <= '0;
            vld_q   <= '0;
            for (int i = 0; i < int'(READ_LAT); i++) begin
                exp_q[i]  <= '0;
                eadx_q[i] <= '0;
            end
        end else begin
            for (int i = int'(READ_LAT) - 1; i > 0; i--) begin
                vld_q[i]  <= vld_q[i-1];
                exp_q[i]  <= exp_q[i-1];
                eadx_q[i] <= eadx_q[i-1];
            end
            vld_q[0]  <= (state_q == S_READ);
            exp_q[0]  <= pattern(adx_q, inv_q);
            eadx_q[0] <= adx_q;

            err_q <= err_d;
            if (mismatch_c && (err_q == '0)) begin
                first_q <= eadx_q[READ_LAT-1];
            end

            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_WRITE;
                        adx_q   <= '0;
                        wren_q  <= 1'b0;
                        wdata_q <= pattern('0, 1'b0);
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        err_q   <= '0;
                        first_q <= '0;
                        inv_q   <= 1'b0;
                    end
                end
                S_WRITE: begin
                    if (adx_q == LAST) begin
                        state_q <= S_READ;
                        adx_q   <= '0;
                        wren_q  <= 1'b1;
                        wdata_q <= '0;
                    end else begin
                        adx_q   <= adx_q + ADDR_W'(1);
                        wdata_q <= pattern(adx_q + ADDR_W'(1), inv_q);
                    end
                end
                S_READ: begin
                    if (adx_q == LAST) begin
                        state_q <= S_DRAIN;
                        adx_q   <= '0;
                        drain_q <= '0;
                    end else begin
                        adx_q <= adx_q + ADDR_W'(1);
                    end
                end
                S_DRAIN: begin
                    // Last compare lands on this edge, so pass uses the updated count
                    if (drain_q == DRAIN_LAST) begin
                        if (TWO_PASS && !inv_q) begin
                            state_q <= S_WRITE;
                            inv_q   <= 1'b1;
                            adx_q   <= '0;
                            wren_q  <= 1'b0;
                            wdata_q <= pattern('0, 1'b1);
                        end else begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (err_d == '0);
                        end
                    end else begin
                        drain_q <= drain_q + 2'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_adx = first_q;
    assign mem_adx       = adx_q;
    assign mem_wren      = wren_q;
    assign mem_wdata     = wdata_q;

endmodule

// File: doc/sram_pattern_tester.md
# sram_pattern_tester

Self-checking sequencer that sits directly upstream of the 2K×16 SRAM block and drives its address, write-enable and write-data lines in place of switch-driven access. On `start` it writes a deterministic address-derived pattern to every location, reads every location back, and compares each word against the expected value. It then reports pass/fail, an error count and the first failing address for display on LEDs/HEX.

## Interface
Parameters:
- `ADDR_W`, 11, SRAM address width
- `DATA_W`, 16, SRAM data width; must be ≥ 16
- `LAST_ADDR`, 2047, highest address tested; sweep is 0..LAST_ADDR
- `READ_LAT`, 1, cycles from read address presented to `mem_rdata` valid; range 1..3

Ports:
- `clk` in 1: single clock, same domain as the SRAM
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a test run; sampled only in IDLE or DONE
- `busy` out 1: run in progress
- `done` out 1: run finished; held until next accepted `start` or `rst`
- `pass` out 1: valid while `done`=1; 1 iff `err_count`==0
- `err_count` out ADDR_W+2: mismatching reads, saturating at all-ones
- `first_err_adx` out ADDR_W: address of the first mismatch in the run
- `mem_adx` out ADDR_W: SRAM address
- `mem_wren` out 1: SRAM `WrEn`; 0 = write, 1 = read/bus released
- `mem_wdata` out DATA_W: write data; the top level tri-states it onto the SRAM bus when `mem_wren`=0
- `mem_rdata` in DATA_W: SRAM bus as read back

## Operation
- Pattern: P(a) = {a[7:0], ~a[7:0]}, zero-extended to DATA_W. The inverted pass uses ~P(a) over all DATA_W bits.
- States:
  - IDLE: on `start`, go to WRITE.
  - WRITE: drives `mem_wren`=0, `mem_adx`=a, `mem_wdata`=pattern(a), with a stepping by 1 per cycle. After a=LAST_ADDR, go to READ.
  - READ: drives `mem_wren`=1 and `mem_adx`=a for a=0..LAST_ADDR, then goes to DRAIN.
  - DRAIN: waits READ_LAT cycles so the last compare completes, then either starts the next pass in WRITE or goes to DONE.
  - DONE: `start` goes to WRITE. Counters and flags clear on the same edge.
- Compare pipeline: the expected word and address are delayed READ_LAT cycles alongside the read request.
  - On mismatch, `err_count` increments, saturating.
  - On the first mismatch of the run, `first_err_adx` captures the address and is then frozen.
- `start` is ignored in WRITE, READ and DRAIN.
- `first_err_adx` stays 0 when the run has no errors.

## Timing
- Reset values: `mem_adx`=0, `mem_wren`=1, `mem_wdata`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `first_err_adx`=0. State is IDLE.
- Start latency: `start` high at edge k gives `busy`=1, `mem_wren`=0, `mem_adx`=0 after edge k.
- Pass length: (LAST_ADDR+1) write cycles + (LAST_ADDR+1) read cycles + READ_LAT drain cycles. With defaults this is 4097 cycles.
- `done`=1 and `busy`=0 on the same edge, immediately after the final drain cycle.
- Boundaries:
  - Address wrap: counter reaching LAST_ADDR changes state and never increments past it. No aliasing to 0 within a phase.
  - `rst` mid-run: on the next edge, all outputs return to reset values with `mem_wren`=1. No further write is issued.
  - `rst` and `start` in the same cycle: `rst` wins.
  - Mismatch on the same cycle as saturation: `err_count` holds all-ones.
  - `mem_wren` never goes low outside WRITE.

## Configuration
- `SRAM_TESTER_INVERT_PASS_EN` defined:
  - Two passes: pass A uses P(a), pass B uses ~P(a).
  - Every data bit is written as both 0 and 1.
  - Run length is 2× a single pass.
  - `err_count` accumulates across both passes.
- Not defined:
  - Pass A only. DRAIN goes directly to DONE.
  - `err_count` upper bit stays 0.

## Test plan
- Ideal SRAM model, defaults, macro on, pulse `start`:
  - `done` after exactly 8194 cycles.
  - `pass`=1, `err_count`=0, `first_err_adx`=0.
- Model with bit 0 stuck at 0, LAST_ADDR=2047, READ_LAT=1:
  - Macro on: `err_count`=2048, `first_err_adx`=0, `pass`=0.
  - Macro off: `err_count`=1024, `first_err_adx`=0, `pass`=0.
- Model where address bit 3 is ignored, LAST_ADDR=15:
  - Reads of a=0..7 return the values written to a+8, so each mismatches.
  - Reads of a=8..15 return their own values.
  - `err_count`=8 per pass, `first_err_adx`=0.
- `rst` asserted at write address 100:
  - Next cycle: all outputs at reset values, `mem_wren`=1.
  - A fresh `start` restarts at `mem_adx`=0.
- `start` pulsed mid-READ: ignored. Total run length unchanged.
- READ_LAT=3 with a model that has 3-cycle read latency:
  - `pass`=1.
  - Run is 4 cycles longer than with READ_LAT=1 (macro on: 2 passes × 2 extra drain cycles).
